mem_port_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares the single-port synchronous memory (clk, addr, wr_enb, wr_data, rd_data) between two independent masters.
- Accepts at most one access per cycle through a valid/ready handshake and drives the memory port.
- Returns read data to the requester that issued the read, with fixed latency and a response-valid strobe.
- Sits directly in front of the memory instance; both masters see a simple request/response interface.

---
 rtl/mem_port_if.sv | 27 ++
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_if.sv
// Request/response channel between one master and the memory port arbiter.
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The master holds valid, we, addr and wdata stable until that edge, and
// valid never depends on ready. rsp_valid is a one-cycle strobe with no
// back-pressure.
interface mem_port_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of a single-port synchronous memory
// (registered read data). Round-robin or fixed priority, one access per cycle.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_port_if.slave             req0,
  mem_port_if.slave             req1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_enb,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  o_dbg_last_grant,
  output logic                  o_dbg_pend_valid,
  output logic                  o_dbg_pend_owner
);

  logic r_last_grant;
  logic r_pend_valid;
  logic r_pend_owner;

  logic w_grant0;
  logic w_grant1;
  logic w_xfer;
  logic w_rd_accept;

  // r_last_grant = 1 means requester 1 won last, so requester 0 wins a tie.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (rst_n) begin
      if (req0.valid && req1.valid) begin
        if ((FIXED_PRIO != 0) || r_last_grant) begin
          w_grant0 = 1'b1;
        end else begin
          w_grant1 = 1'b1;
        end
      end else begin
        w_grant0 = req0.valid;
        w_grant1 = req1.valid;
      end
    end
  end

  assign req0.ready  = w_grant0;
  assign req1.ready  = w_grant1;
  assign w_xfer      = w_grant0 | w_grant1;
  assign w_rd_accept = w_xfer & ~mem_wr_enb;

  always_comb begin
    mem_addr    = '0;
    mem_wr_enb  = 1'b0;
    mem_wr_data = '0;
    if (w_grant0) begin
      mem_addr    = req0.addr;
      mem_wr_enb  = req0.we;
      mem_wr_data = req0.wdata;
    end else if (w_grant1) begin
      mem_addr    = req1.addr;
      mem_wr_enb  = req1.we;
      mem_wr_data = req1.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_pend_valid <= 1'b0;
      r_pend_owner <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_last_grant <= w_grant1;
      end
      r_pend_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_pend_owner <= w_grant1;
      end
    end
  end

  // Gating with rst_n drops a response whose read was accepted just before reset.
  assign req0.rsp_valid = rst_n & r_pend_valid & ~r_pend_owner;
  assign req1.rsp_valid = rst_n & r_pend_valid &  r_pend_owner;
  assign req0.rsp_rdata = req0.rsp_valid ? mem_rd_data : '0;
  assign req1.rsp_rdata = req1.rsp_valid ? mem_rd_data : '0;

  assign o_dbg_last_grant = r_last_grant;
  assign o_dbg_pend_valid = r_pend_valid;
  assign o_dbg_pend_owner = r_pend_owner;

  a_grant_onehot : assert property (@(posedge clk) !(w_grant0 && w_grant1));

  a_req0_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (req0.valid && !req0.ready) |=>
      (req0.valid && $stable(req0.we) && $stable(req0.addr) && $stable(req0.wdata)));

  a_req1_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (req1.valid && !req1.ready) |=>
      (req1.valid && $stable(req1.we) && $stable(req1.addr) && $stable(req1.wdata)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: round-robin instance plus a
// fixed-priority instance, each in front of a behavioural registered-read memory.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mem_port_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) a0 ();
  mem_port_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) a1 ();
  mem_port_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) b0 ();
  mem_port_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) b1 ();

  logic [3:0] a_addr, b_addr;
  logic       a_we, b_we;
  logic [7:0] a_wd, b_wd, a_rd, b_rd;
  logic       a_dbg_last, a_dbg_pv, a_dbg_po;
  logic       b_dbg_last, b_dbg_pv, b_dbg_po;
  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];

  mem_port_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .req0(a0), .req1(a1),
    .mem_addr(a_addr), .mem_wr_enb(a_we), .mem_wr_data(a_wd), .mem_rd_data(a_rd),
    .o_dbg_last_grant(a_dbg_last), .o_dbg_pend_valid(a_dbg_pv), .o_dbg_pend_owner(a_dbg_po)
  );

  mem_port_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .req0(b0), .req1(b1),
    .mem_addr(b_addr), .mem_wr_enb(b_we), .mem_wr_data(b_wd), .mem_rd_data(b_rd),
    .o_dbg_last_grant(b_dbg_last), .o_dbg_pend_valid(b_dbg_pv), .o_dbg_pend_owner(b_dbg_po)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_we) mem_a[a_addr] <= a_wd;
    a_rd <= mem_a[a_addr];
    if (b_we) mem_b[b_addr] <= b_wd;
    b_rd <= mem_b[b_addr];
  end

  // driver tasks
  task automatic drv(input int p, input logic v, input logic we,
                     input logic [3:0] addr, input logic [7:0] wd);
    case (p)
      0: begin a0.valid = v; a0.we = we; a0.addr = addr; a0.wdata = wd; end
      1: begin a1.valid = v; a1.we = we; a1.addr = addr; a1.wdata = wd; end
      2: begin b0.valid = v; b0.we = we; b0.addr = addr; b0.wdata = wd; end
      default: begin b1.valid = v; b1.we = we; b1.addr = addr; b1.wdata = wd; end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drv(0, 1'b1, 1'b1, 4'd0, 8'h5A);
    drv(1, 1'b1, 1'b0, 4'd0, 8'h00);
    drv(2, 1'b0, 1'b0, 4'd0, 8'h00);
    drv(3, 1'b0, 1'b0, 4'd0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    settle();
    check("rst_rdy0", a0.ready, 0);
    check("rst_rdy1", a1.ready, 0);
    check("rst_wr_enb", a_we, 0);
    check("rst_rsp0_v", a0.rsp_valid, 0);
    check("rst_rsp1_v", a1.rsp_valid, 0);
    check("rst_last", a_dbg_last, 1);

    // release: requester 0 wins the first conflict
    rst_n = 1'b1;
    settle();
    check("rel_rdy0", a0.ready, 1);
    check("rel_rdy1", a1.ready, 0);
    check("rel_wr_enb", a_we, 1);
    check("rel_wdata", a_wd, 8'h5A);
    step();
    drv(0, 1'b0, 1'b0, 4'd0, 8'h00);
    settle();
    check("c2_rdy1", a1.ready, 1);
    check("c2_wr_enb", a_we, 0);
    step();

    // single requester write then read-after-write
    drv(1, 1'b0, 1'b0, 4'd0, 8'h00);
    drv(0, 1'b1, 1'b1, 4'd3, 8'hA5);
    settle();
    check("c3_rsp1_v", a1.rsp_valid, 1);
    check("c3_rsp1_d", a1.rsp_rdata, 8'h5A);
    check("c3_rsp0_v", a0.rsp_valid, 0);
    check("c3_rdy0", a0.ready, 1);
    step();
    drv(0, 1'b1, 1'b0, 4'd3, 8'h00);
    settle();
    check("c4_rsp1_v", a1.rsp_valid, 0);
    check("c4_addr", a_addr, 3);
    step();

    // write accepted while the read response is outstanding
    drv(0, 1'b1, 1'b1, 4'd1, 8'h11);
    settle();
    check("c5_rsp0_v", a0.rsp_valid, 1);
    check("c5_rsp0_d", a0.rsp_rdata, 8'hA5);
    check("c5_rsp1_v", a1.rsp_valid, 0);
    check("c5_wr_enb", a_we, 1);
    step();
    drv(0, 1'b0, 1'b0, 4'd0, 8'h00);
    drv(1, 1'b1, 1'b1, 4'd2, 8'h22);
    settle();
    check("c6_rsp0_v", a0.rsp_valid, 0);
    check("c6_rdy1", a1.ready, 1);
    step();

    // round-robin conflict: grants 0,1,0,1
    drv(0, 1'b1, 1'b0, 4'd1, 8'h00);
    drv(1, 1'b1, 1'b0, 4'd2, 8'h00);
    settle();
    check("c7_rdy0", a0.ready, 1);
    check("c7_rdy1", a1.ready, 0);
    check("c7_addr", a_addr, 1);
    step();
    settle();
    check("c8_rdy1", a1.ready, 1);
    check("c8_rsp0_d", a0.rsp_rdata, 8'h11);
    step();
    settle();
    check("c9_rdy0", a0.ready, 1);
    check("c9_rsp1_d", a1.rsp_rdata, 8'h22);
    step();
    settle();
    check("c10_rdy1", a1.ready, 1);
    check("c10_rsp0_d", a0.rsp_rdata, 8'h11);
    step();
    drv(1, 1'b0, 1'b0, 4'd0, 8'h00);
    settle();
    check("c11_rdy0", a0.ready, 1);
    check("c11_rsp1_v", a1.rsp_valid, 1);
    check("c11_rsp1_d", a1.rsp_rdata, 8'h22);
    step();
    drv(0, 1'b0, 1'b0, 4'd0, 8'h00);
    drv(1, 1'b1, 1'b0, 4'd2, 8'h00);
    settle();
    check("c12_rsp0_d", a0.rsp_rdata, 8'h11);
    check("c12_rdy1", a1.ready, 1);
    step();

    // mixed traffic: write and read of the same address in one cycle
    drv(0, 1'b1, 1'b1, 4'd7, 8'h3C);
    drv(1, 1'b1, 1'b0, 4'd7, 8'h00);
    settle();
    check("c13_rsp1_d", a1.rsp_rdata, 8'h22);
    check("c13_rdy0", a0.ready, 1);
    check("c13_rdy1", a1.ready, 0);
    check("c13_addr", a_addr, 7);
    check("c13_wdata", a_wd, 8'h3C);
    step();
    drv(0, 1'b0, 1'b0, 4'd0, 8'h00);
    settle();
    check("c14_rdy1", a1.ready, 1);
    check("c14_wr_enb", a_we, 0);
    check("c14_rsp0_v", a0.rsp_valid, 0);
    check("c14_rsp1_v", a1.rsp_valid, 0);
    step();
    drv(1, 1'b1, 1'b0, 4'd2, 8'h00);
    settle();
    check("c15_rsp1_v", a1.rsp_valid, 1);
    check("c15_rsp1_d", a1.rsp_rdata, 8'h3C);
    check("c15_rdy1", a1.ready, 1);
    step();

    // reset while a read from requester 1 is in flight
    drv(1, 1'b0, 1'b0, 4'd0, 8'h00);
    rst_n = 1'b0;
    settle();
    check("c16_rsp1_v", a1.rsp_valid, 0);
    step();
    settle();
    check("c17_rsp1_v", a1.rsp_valid, 0);
    check("c17_pend", a_dbg_pv, 0);
    check("c17_last", a_dbg_last, 1);
    rst_n = 1'b1;
    drv(0, 1'b1, 1'b0, 4'd1, 8'h00);
    drv(1, 1'b1, 1'b0, 4'd2, 8'h00);
    settle();
    check("c17_rdy0", a0.ready, 1);
    check("c17_rdy1", a1.ready, 0);
    step();
    drv(0, 1'b0, 1'b0, 4'd0, 8'h00);
    settle();
    check("c18_rsp0_d", a0.rsp_rdata, 8'h11);
    check("c18_rsp1_v", a1.rsp_valid, 0);
    check("c18_rdy1", a1.ready, 1);
    step();
    drv(1, 1'b0, 1'b0, 4'd0, 8'h00);
    settle();
    check("c19_rsp1_d", a1.rsp_rdata, 8'h22);
    step();
    settle();
    check("c20_rsp0_v", a0.rsp_valid, 0);
    check("c20_rsp1_v", a1.rsp_valid, 0);

    // fixed priority: requester 0 wins every conflict
    drv(2, 1'b1, 1'b0, 4'd0, 8'h00);
    drv(3, 1'b1, 1'b0, 4'd0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("fp_rdy0", b0.ready, 1);
      check("fp_rdy1", b1.ready, 0);
      if (i > 0) check("fp_rsp0_v", b0.rsp_valid, 1);
      step();
    end
    drv(2, 1'b0, 1'b0, 4'd0, 8'h00);
    settle();
    check("fp_drop_rdy1", b1.ready, 1);
    check("fp_drop_rdy0", b0.ready, 0);
    step();
    drv(3, 1'b0, 1'b0, 4'd0, 8'h00);
    settle();
    check("fp_rsp1_v", b1.rsp_valid, 1);
    check("fp_rsp0_v_end", b0.rsp_valid, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
